// File: rtl/case4_sched_if.sv
// Bundle of the two request channels, the case4 datapath drive/return and the response channel.
// The scheduler takes the slave view; client logic and the datapath wrapper take the master view.
interface case4_sched_if;
  logic       req0_valid;
  logic [6:0] req0_vec;
  logic       req0_ready;
  logic       req1_valid;
  logic [6:0] req1_vec;
  logic       req1_ready;
  logic [6:0] dp_vec;
  logic       dp_x;
  logic       dp_y;
  logic       dp_z;
  logic       rsp_valid;
  logic       rsp_ready;
  logic       rsp_id;
  logic [2:0] rsp_xyz;
  logic       rsp_err;
  logic [7:0] done_cnt;

  modport slave (
    input  req0_valid, req0_vec, req1_valid, req1_vec,
    input  dp_x, dp_y, dp_z, rsp_ready,
    output req0_ready, req1_ready, dp_vec,
    output rsp_valid, rsp_id, rsp_xyz, rsp_err, done_cnt
  );

  modport master (
    output req0_valid, req0_vec, req1_valid, req1_vec,
    output dp_x, dp_y, dp_z, rsp_ready,
    input  req0_ready, req1_ready, dp_vec,
    input  rsp_valid, rsp_id, rsp_xyz, rsp_err, done_cnt
  );
endinterface

// File: rtl/case4_sched.sv
// Round-robin two-client scheduler sharing one combinational case4 datapath (a..g -> x,y,z).
// Optional feature: define CASE4_SCHED_CHECK_EN to build an internal case4 model that flags mismatches on rsp_err.
module case4_sched #(
  parameter int SETTLE = 1
) (
  input logic          clk,
  input logic          rst,
  case4_sched_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    RESP  = 2'd2
  } state_t;

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE - 1);

  state_t     state_q;
  state_t     state_d;
  logic       last_q;
  logic [3:0] cnt_q;

  logic       gnt0;
  logic       gnt1;
  logic       accept;
  logic       capture;
  logic       handshake;
  logic [6:0] accept_vec;

  logic [6:0] dp_vec_p0;
  logic       rsp_id_p0;
  logic       vld_p1;
  logic [2:0] rsp_xyz_p1;
  logic [7:0] done_cnt_q;

  // Next-state and arbitration; readies only leave IDLE when out of reset.
  always_comb begin
    state_d   = state_q;
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    capture   = 1'b0;
    handshake = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rst) begin
          gnt0 = bus.req0_valid && (!bus.req1_valid || last_q);
          gnt1 = bus.req1_valid && (!bus.req0_valid || !last_q);
        end
        if (gnt0 || gnt1) begin
          state_d = DRIVE;
        end
      end
      DRIVE: begin
        if (cnt_q == 4'd0) begin
          capture = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        if (vld_p1 && bus.rsp_ready) begin
          handshake = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign accept     = gnt0 || gnt1;
  assign accept_vec = gnt1 ? bus.req1_vec : bus.req0_vec;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // last starts at 1 so requester 0 wins the first contention.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= 1'b1;
      cnt_q  <= 4'd0;
    end else if (accept) begin
      last_q <= gnt1;
      cnt_q  <= SETTLE_LOAD;
    end else if (state_q == DRIVE && cnt_q != 4'd0) begin
      cnt_q <= cnt_q - 4'd1;
    end
  end

  // Drive stage: vector and owner latched on accept, held until the next accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      dp_vec_p0 <= 7'd0;
      rsp_id_p0 <= 1'b0;
    end else if (accept) begin
      dp_vec_p0 <= accept_vec;
      rsp_id_p0 <= gnt1;
    end
  end

  // Capture stage: datapath outputs sampled once the settle window has elapsed.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1     <= 1'b0;
      rsp_xyz_p1 <= 3'd0;
      done_cnt_q <= 8'd0;
    end else if (capture) begin
      vld_p1     <= 1'b1;
      rsp_xyz_p1 <= {bus.dp_x, bus.dp_y, bus.dp_z};
    end else if (handshake) begin
      vld_p1     <= 1'b0;
      done_cnt_q <= done_cnt_q + 8'd1;
    end
  end

`ifdef CASE4_SCHED_CHECK_EN
  function automatic logic [2:0] case4_expect(input logic [6:0] v);
    logic a, b, c, d, e, f, g;
    {a, b, c, d, e, f, g} = v;
    case4_expect = {a & b & e, ~(b & d & e), ~(c & d & e & f & g)};
  endfunction

  logic rsp_err_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_err_p1 <= 1'b0;
    end else if (capture) begin
      rsp_err_p1 <= ({bus.dp_x, bus.dp_y, bus.dp_z} != case4_expect(dp_vec_p0));
    end else if (handshake) begin
      rsp_err_p1 <= 1'b0;
    end
  end

  assign bus.rsp_err = rsp_err_p1;
`else
  assign bus.rsp_err = 1'b0;
`endif

  assign bus.req0_ready = gnt0;
  assign bus.req1_ready = gnt1;
  assign bus.dp_vec     = dp_vec_p0;
  assign bus.rsp_valid  = vld_p1;
  assign bus.rsp_id     = rsp_id_p0;
  assign bus.rsp_xyz    = rsp_xyz_p1;
  assign bus.done_cnt   = done_cnt_q;

endmodule
